// File: rtl/handshake_data_to_ctrl.sv
// Converts a valid/ready data channel into indistinguishable control tokens held as a count.
// Optional payload check against EXPECTED is built only when HANDSHAKE_DATA_CHECK_EN is defined.
module handshake_data_to_ctrl #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] EXPECTED   = DATA_WIDTH'(32'h0001E6D7)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic [3:0]            occupancy,
    output logic                  mismatch,
    output logic [7:0]            mismatch_cnt,
    output logic [DATA_WIDTH-1:0] first_bad
);

    localparam logic [3:0] DepthLim = 4'(DEPTH);

    logic [3:0] occ_q, occ_d;
    logic       in_fire;
    logic       out_fire;

    // Handshake outputs depend on the registered count only.
    assign ins_ready  = (occ_q < DepthLim);
    assign ctrl_valid = (occ_q != 4'd0);
    assign in_fire    = ins_valid & ins_ready;
    assign out_fire   = ctrl_valid & ctrl_ready;
    assign occupancy  = occ_q;

    always_comb begin
        occ_d = occ_q;
        if (in_fire && !out_fire) begin
            occ_d = occ_q + 4'd1;
        end else if (!in_fire && out_fire) begin
            occ_d = occ_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= 4'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef HANDSHAKE_DATA_CHECK_EN
    logic                  mismatch_q, mismatch_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] first_bad_q, first_bad_d;
    logic                  bad;

    assign bad = in_fire && (ins != EXPECTED);

    always_comb begin
        mismatch_d  = mismatch_q | bad;
        cnt_d       = cnt_q;
        first_bad_d = first_bad_q;
        if (bad && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (bad && !mismatch_q) begin
            first_bad_d = ins;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch_q  <= 1'b0;
            cnt_q       <= 8'd0;
            first_bad_q <= '0;
        end else begin
            mismatch_q  <= mismatch_d;
            cnt_q       <= cnt_d;
            first_bad_q <= first_bad_d;
        end
    end

    assign mismatch     = mismatch_q;
    assign mismatch_cnt = cnt_q;
    assign first_bad    = first_bad_q;
`else
    // Payload is discarded entirely in this build.
    logic unused_ins;
    assign unused_ins   = ^ins;
    assign mismatch     = 1'b0;
    assign mismatch_cnt = 8'd0;
    assign first_bad    = '0;
`endif

endmodule

// File: tb/tb_handshake_data_to_ctrl.sv
// Scoreboard bench for handshake_data_to_ctrl: tokens are queued on modelled accepts and
// retired on modelled pops; every cycle the DUT outputs are compared with the model.
module tb_handshake_data_to_ctrl;

    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] EXP    = 32'h0001E6D7;
`ifdef HANDSHAKE_DATA_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] ins = '0;
    logic          ins_valid = 1'b0;
    logic          ins_ready;
    logic          ctrl_valid;
    logic          ctrl_ready = 1'b0;
    logic [3:0]    occupancy;
    logic          mismatch;
    logic [7:0]    mismatch_cnt;
    logic [DW-1:0] first_bad;

    int n_total = 0;
    int n_bad   = 0;

    int unsigned tok_q[$];
    int unsigned tok_id  = 0;
    int          accepts = 0;

    logic          m_mis   = 1'b0;
    logic [7:0]    m_cnt   = 8'd0;
    logic [DW-1:0] m_first = '0;

    handshake_data_to_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .EXPECTED   (EXP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ins          (ins),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .ctrl_valid   (ctrl_valid),
        .ctrl_ready   (ctrl_ready),
        .occupancy    (occupancy),
        .mismatch     (mismatch),
        .mismatch_cnt (mismatch_cnt),
        .first_bad    (first_bad)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int unsigned m_occ;
        m_occ = tok_q.size();
        check_val({tag, ".occ"}, 32'(occupancy), m_occ);
        check_val({tag, ".ins_ready"}, 32'(ins_ready), 32'(m_occ < DEPTH));
        check_val({tag, ".ctrl_valid"}, 32'(ctrl_valid), 32'(m_occ != 0));
        check_val({tag, ".mismatch"}, 32'(mismatch), 32'(m_mis));
        check_val({tag, ".mis_cnt"}, 32'(mismatch_cnt), 32'(m_cnt));
        check_val({tag, ".first_bad"}, first_bad, m_first);
    endtask

    task automatic reset_model();
        tok_q.delete();
        m_mis   = 1'b0;
        m_cnt   = 8'd0;
        m_first = '0;
    endtask

    // One clock cycle: drive, check registered outputs, advance model, clock.
    task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] d, input logic cr);
        logic in_fire, out_fire;
        ins_valid  = iv;
        ins        = d;
        ctrl_ready = cr;
        #1;
        check_outputs(tag);
        in_fire  = iv && (tok_q.size() < DEPTH);
        out_fire = cr && (tok_q.size() != 0);
        if (iv && ins_ready) accepts++;
        if (out_fire) void'(tok_q.pop_front());
        if (in_fire) begin
            tok_q.push_back(tok_id);
            tok_id++;
            if (CheckEn && (d != EXP)) begin
                if (!m_mis) m_first = d;
                m_mis = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b1;

        // Single token with matching data; visible next cycle.
        cycle("one_push", 1'b1, EXP, 1'b0);
        cycle("one_seen", 1'b0, EXP, 1'b0);
        check_val("one.occ_is_1", 32'(occupancy), 32'd1);

        // Drain, then fill with ctrl_ready low for 6 cycles.
        cycle("drain", 1'b0, EXP, 1'b1);
        accepts = 0;
        for (int i = 0; i < 6; i++) cycle("fill", 1'b1, EXP, 1'b0);
        check_val("fill.accepts", 32'(accepts), 32'd4);
        check_val("fill.occ_is_4", 32'(occupancy), 32'd4);

        // Full with both sides active: pop-only first, then steady push+pop at 3.
        for (int i = 0; i < 5; i++) cycle("full_flow", 1'b1, EXP, 1'b1);
        check_val("flow.occ_is_3", 32'(occupancy), 32'd3);

        for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, EXP, 1'b1);
        cycle("bad1", 1'b1, 32'hDEADBEEF, 1'b0);
        cycle("bad2", 1'b1, 32'h00000001, 1'b0);
        cycle("bad_seen", 1'b0, EXP, 1'b1);
        check_val("bad.cnt2", 32'(mismatch_cnt), CheckEn ? 32'd2 : 32'd0);
        check_val("bad.first", first_bad, CheckEn ? 32'hDEADBEEF : 32'd0);
        for (int i = 0; i < 300; i++) cycle("sat", 1'b1, 32'hBAD0_0000 + i, 1'b1);
        cycle("sat_seen", 1'b0, EXP, 1'b1);
        check_val("sat.cnt255", 32'(mismatch_cnt), CheckEn ? 32'd255 : 32'd0);

        // Build occupancy 3, then reset between edges.
        for (int i = 0; i < 4; i++) cycle("drain3", 1'b0, EXP, 1'b1);
        for (int i = 0; i < 3; i++) cycle("to3", 1'b1, EXP, 1'b0);
        cycle("at3", 1'b0, EXP, 1'b0);
        check_val("async.pre_occ", 32'(occupancy), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_val("async.occ", 32'(occupancy), 32'd0);
        check_val("async.ctrl_valid", 32'(ctrl_valid), 32'd0);
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("async.ins_ready", 32'(ins_ready), 32'd1);
        cycle("post_rst_push", 1'b1, EXP, 1'b0);
        cycle("post_rst_seen", 1'b0, EXP, 1'b0);
        check_val("post_rst.occ", 32'(occupancy), 32'd1);

        for (int i = 0; i < 10000; i++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP;
            cycle("rand", 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
        end
        check_outputs("final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
